ws2812_pattern_gen: RTL

Parametrised test-pattern source for the ws2812 LED-chain driver. It walks led_num from 0 to NUM_LEDS-1 and presents a colour and a write strobe for each LED, one LED every WRITE_GAP clocks. It supports four selectable modes and a ready handshake so the driver can apply backpressure. It sits in the top level between the board clock/reset and the ws2812 instance.

---
 rtl/ws2812_pattern_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_pattern_gen.sv
`default_nettype none
// ============================================================================
// ws2812_pattern_gen : test-pattern source (colour-cycle/chase/rainbow/blank)
// Revision: 1.0
// ============================================================================
module ws2812_pattern_gen #(
  parameter int         NUM_LEDS     = 8,
  parameter int         LED_NUM_W    = 8,
  parameter int         WRITE_GAP    = 524288,
  parameter logic [7:0] LEVEL        = 8'h10,
  parameter int         HUE_STEP     = 24,
  parameter int         BRIGHT_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 ready,
  output logic                 write,
  output logic [LED_NUM_W-1:0] led_num,
  output logic [23:0]          rgb_data,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt
);

  localparam int                   GAP_W    = $clog2(WRITE_GAP);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(WRITE_GAP - 1);
  localparam logic [LED_NUM_W-1:0] LAST_LED = LED_NUM_W'(NUM_LEDS - 1);
  localparam logic [8:0]           HSTEP    = 9'(HUE_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t                r_state, w_next_state;
  logic [GAP_W-1:0]      r_gap;
  logic [1:0]            r_mode;
  logic [LED_NUM_W-1:0]  r_chase;
  logic [7:0]            r_hue_base;
  logic [7:0]            r_hue_led;
  logic                  w_start, w_load, w_accept, w_wrap;
  logic [8:0]            w_hue_sum;
  logic [7:0]            w_hue_led_next, w_hue_base_next;
  logic [LED_NUM_W-1:0]  w_chase_next;
  logic [5:0]            w_r, w_inv;
  logic [23:0]           w_colour;

  function automatic logic [7:0] chan(input logic [5:0] c);
    logic [7:0] full;
    full = {c, 2'b00};
    return full >> BRIGHT_SHIFT;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    w_wrap       = 1'b0;
    case (r_state)
      S_IDLE: if (enable) begin
        w_start      = 1'b1;
        w_next_state = S_GAP;
      end
      S_GAP: if (r_gap == GAP_LAST) begin
        w_load       = 1'b1;
        w_next_state = S_REQ;
      end
      S_REQ: if (ready) begin
        w_accept = 1'b1;
        if (led_num == LAST_LED) begin
          w_wrap       = 1'b1;
          w_next_state = enable ? S_GAP : S_IDLE;
        end else begin
          w_next_state = S_GAP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-LED hue advances by HUE_STEP with a single conditional subtract of 192.
  assign w_hue_sum       = {1'b0, r_hue_led} + HSTEP;
  assign w_hue_led_next  = (w_hue_sum >= 9'd192) ? 8'(w_hue_sum - 9'd192) : w_hue_sum[7:0];
  assign w_hue_base_next = (r_hue_base == 8'd191) ? 8'd0 : r_hue_base + 8'd1;
  assign w_chase_next    = (r_chase == LAST_LED) ? '0 : r_chase + LED_NUM_W'(1);

  assign w_r   = r_hue_led[5:0];
  assign w_inv = 6'd63 - w_r;

  always_comb begin
    w_colour = 24'h0;
    case (r_mode)
      2'd0: case (frame_cnt[1:0])
        2'd0:    w_colour = {LEVEL, 8'h00, 8'h00};
        2'd1:    w_colour = {8'h00, LEVEL, 8'h00};
        2'd2:    w_colour = {8'h00, 8'h00, LEVEL};
        default: w_colour = {LEVEL, LEVEL, LEVEL};
      endcase
      2'd1: if (led_num == r_chase) w_colour = {LEVEL, LEVEL, LEVEL};
      2'd2: case (r_hue_led[7:6])
        2'd0:    w_colour = {chan(w_inv), chan(w_r), 8'h00};
        2'd1:    w_colour = {8'h00, chan(w_inv), chan(w_r)};
        2'd2:    w_colour = {chan(w_r), 8'h00, chan(w_inv)};
        default: w_colour = 24'h0;
      endcase
      default: w_colour = 24'h0;
    endcase
  end

  assign write = (r_state == S_REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_mode     <= 2'd0;
      r_chase    <= '0;
      r_hue_base <= 8'd0;
      r_hue_led  <= 8'd0;
      led_num    <= '0;
      rgb_data   <= 24'h0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      frame_done <= w_wrap;
      if (w_start) begin
        r_mode    <= mode;
        led_num   <= '0;
        r_gap     <= '0;
        r_hue_led <= r_hue_base;
      end
      if (r_state == S_GAP) begin
        r_gap <= w_load ? '0 : r_gap + GAP_W'(1);
      end
      if (w_load) begin
        rgb_data <= w_colour;
      end
      if (w_accept) begin
        r_gap <= '0;
        if (w_wrap) begin
          led_num    <= '0;
          frame_cnt  <= frame_cnt + 16'd1;
          r_chase    <= w_chase_next;
          r_hue_base <= w_hue_base_next;
          r_hue_led  <= w_hue_base_next;
          r_mode     <= mode;
        end else begin
          led_num   <= led_num + LED_NUM_W'(1);
          r_hue_led <= w_hue_led_next;
        end
      end
    end
  end

endmodule
`default_nettype wire
